// File: rtl/musa_if_pkg.sv
// Shared IF-stage constants, FSM encoding and fault codes for the PC sequencer.
package musa_if_pkg;

  localparam int PC_W  = 13;
  localparam int DEPTH = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    FAULT    = 2'd2
  } pcState_t;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_OVF  = 2'b01,
    FLT_UNF  = 2'b10,
    FLT_STK  = 2'b11
  } fault_t;

endpackage

// File: rtl/pc_depth_counter.sv
// Saturating up/down counter 0..DEPTH with full/empty flags; 1-cycle update,
// an increment at full or a decrement at empty is ignored.
module pc_depth_counter #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + CW'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_flow_controller.sv
// Fetch-PC sequencer and return-stack guard: call/branch/seq in 1 cycle, return in 2.
// en=0 stalls RUN and drops requests; busy flags the RET_WAIT cycle, when UC requests are ignored.
module pc_flow_controller #(
  parameter int              PC_W     = musa_if_pkg::PC_W,
  parameter int              DEPTH    = musa_if_pkg::DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            branch,
  input  logic [PC_W-1:0] branch_target,
  input  logic            call,
  input  logic [PC_W-1:0] call_target,
  input  logic            ret,
  input  logic [PC_W-1:0] stack_pop_data,
  input  logic            stack_overflow,
  output logic [PC_W-1:0] pc,
  output logic            stack_push,
  output logic            stack_pop,
  output logic [PC_W-1:0] stack_push_data,
  output logic            busy,
  output logic [1:0]      fault,
  output logic [3:0]      depth
);

  import musa_if_pkg::*;

  pcState_t        state, nextState;
  fault_t          faultQ, nextFault;
  logic [PC_W-1:0] nextPc;
  logic [PC_W-1:0] pcPlusOne;
  logic            stackFull, stackEmpty;

  assign pcPlusOne       = pc + PC_W'(1);
  assign stack_push_data = pcPlusOne;
  assign busy            = (state == RET_WAIT);
  assign fault           = faultQ;

  pc_depth_counter #(
    .DEPTH (DEPTH),
    .CW    (4)
  ) depthCounter (
    .clk   (clk),
    .reset (reset),
    .inc   (stack_push),
    .dec   (stack_pop),
    .count (depth),
    .full  (stackFull),
    .empty (stackEmpty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      pc     <= RESET_PC;
      faultQ <= FLT_NONE;
    end else begin
      state  <= nextState;
      pc     <= nextPc;
      faultQ <= nextFault;
    end
  end

  always_comb begin
    nextState  = state;
    nextPc     = pc;
    nextFault  = faultQ;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    case (state)
      RUN: begin
        // The stack's own error outranks every UC request, including the stall.
        if (stack_overflow) begin
          nextState = FAULT;
          nextFault = FLT_STK;
        end else if (en) begin
          if (ret) begin
            if (!stackEmpty) begin
              stack_pop = 1'b1;
              nextState = RET_WAIT;
            end else begin
              nextState = FAULT;
              nextFault = FLT_UNF;
            end
          end else if (call) begin
            if (!stackFull) begin
              stack_push = 1'b1;
              nextPc     = call_target;
            end else begin
              nextState = FAULT;
              nextFault = FLT_OVF;
            end
          end else if (branch) begin
            nextPc = branch_target;
          end else begin
            nextPc = pcPlusOne;
          end
        end
      end
      RET_WAIT: begin
        if (stack_overflow) begin
          nextState = FAULT;
          nextFault = FLT_STK;
        end else begin
          nextPc    = stack_pop_data;
          nextState = RUN;
        end
      end
      default: begin
        nextState = FAULT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_flow_controller.sv
// Directed bench for pc_flow_controller: expectations queued per step, compared against DUT outputs.
module tb_pc_flow_controller;

  logic        clk = 1'b0;
  logic        rstN;
  logic        en, branch, call, ret, stackOverflow;
  logic [12:0] branchTarget, callTarget, stackPopData;
  logic [12:0] pc, pushData;
  logic        push, pop, busy;
  logic [1:0]  fault;
  logic [3:0]  depth;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       tag;
    logic        push;
    logic        pop;
    logic [12:0] pushData;
    logic [12:0] pc;
    logic [3:0]  depth;
    logic [1:0]  fault;
    logic        busy;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  pc_flow_controller #(.PC_W(13), .DEPTH(8), .RESET_PC(13'd0)) dut (
    .clk             (clk),
    .reset           (rstN),
    .en              (en),
    .branch          (branch),
    .branch_target   (branchTarget),
    .call            (call),
    .call_target     (callTarget),
    .ret             (ret),
    .stack_pop_data  (stackPopData),
    .stack_overflow  (stackOverflow),
    .pc              (pc),
    .stack_push      (push),
    .stack_pop       (pop),
    .stack_push_data (pushData),
    .busy            (busy),
    .fault           (fault),
    .depth           (depth)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idleInputs();
    en = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; stackOverflow = 1'b0;
    branchTarget = '0; callTarget = '0; stackPopData = '0;
  endtask

  // Drive one cycle of stimulus at negedge; strobes checked before the edge, state after it.
  task automatic step(input string tag, input logic e, input logic b, input logic [12:0] bt,
                      input logic c, input logic [12:0] ct, input logic r, input logic [12:0] pd,
                      input logic ov, input logic xPush, input logic xPop, input logic [12:0] xData,
                      input logic [12:0] xPc, input logic [3:0] xDepth, input logic [1:0] xFault,
                      input logic xBusy);
    exp_t x;
    en = e; branch = b; branchTarget = bt; call = c; callTarget = ct; ret = r;
    stackPopData = pd; stackOverflow = ov;
    x = '{tag, xPush, xPop, xData, xPc, xDepth, xFault, xBusy};
    expQ.push_back(x);
    #1;
    chk({x.tag, ".push"}, 32'(push), 32'(x.push));
    chk({x.tag, ".pop"}, 32'(pop), 32'(x.pop));
    if (x.push) chk({x.tag, ".pushData"}, 32'(pushData), 32'(x.pushData));
    @(negedge clk);
    x = expQ.pop_front();
    chk({x.tag, ".pc"}, 32'(pc), 32'(x.pc));
    chk({x.tag, ".depth"}, 32'(depth), 32'(x.depth));
    chk({x.tag, ".fault"}, 32'(fault), 32'(x.fault));
    chk({x.tag, ".busy"}, 32'(busy), 32'(x.busy));
  endtask

  task automatic doReset(input string tag);
    rstN = 1'b0;
    idleInputs();
    #1;
    chk({tag, ".pc"}, 32'(pc), 32'd0);
    chk({tag, ".depth"}, 32'(depth), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".strobes"}, 32'({push, pop}), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, failed + 1);
  end

  initial begin
    rstN = 1'b0;
    idleInputs();
    @(negedge clk);
    doReset("reset0");

    // Sequential fetch 0 -> 4.
    for (int i = 1; i <= 4; i++)
      step($sformatf("seq%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'(i), 0, 0, 0);
    step("br10", 1, 1, 13'd10, 0, 0, 0, 0, 0, 0, 0, 0, 13'd10, 0, 0, 0);

    // Call then return.
    step("call100", 1, 0, 0, 1, 13'h100, 0, 0, 0, 1, 0, 13'd11, 13'h100, 1, 0, 0);
    step("ret", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 13'h100, 0, 0, 1);
    step("retwait", 1, 0, 0, 1, 13'h777, 0, 13'd11, 0, 0, 0, 0, 13'd11, 0, 0, 0);

    // Stall drops requests.
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), 0, 1, 13'h55, 1, 13'h66, 1, 0, 0, 0, 0, 0, 13'd11, 0, 0, 0);

    // Priority: ret beats call and branch; call beats branch.
    step("call200", 1, 0, 0, 1, 13'h200, 0, 0, 0, 1, 0, 13'd12, 13'h200, 1, 0, 0);
    step("prioRet", 1, 1, 13'h50, 1, 13'h60, 1, 0, 0, 0, 1, 0, 13'h200, 0, 0, 1);
    step("prioRetW", 1, 0, 0, 0, 0, 0, 13'd12, 0, 0, 0, 0, 13'd12, 0, 0, 0);
    step("prioCall", 1, 1, 13'h50, 1, 13'h300, 0, 0, 0, 1, 0, 13'd13, 13'h300, 1, 0, 0);
    step("ret2", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 13'h300, 0, 0, 1);
    step("ret2W", 0, 0, 0, 0, 0, 0, 13'd13, 0, 0, 0, 0, 13'd13, 0, 0, 0);

    // PC wrap on push data and on sequential fetch.
    step("brMax", 1, 1, 13'h1FFF, 0, 0, 0, 0, 0, 0, 0, 0, 13'h1FFF, 0, 0, 0);
    step("callWrap", 1, 0, 0, 1, 13'h20, 0, 0, 0, 1, 0, 13'd0, 13'h20, 1, 0, 0);
    step("brMax2", 1, 1, 13'h1FFF, 0, 0, 0, 0, 0, 0, 0, 0, 13'h1FFF, 1, 0, 0);
    step("seqWrap", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'd0, 1, 0, 0);

    // Reset during RET_WAIT aborts the return.
    step("retAbort", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 13'd0, 0, 0, 1);
    stackPopData = 13'h55;
    doReset("resetRetWait");
    step("postAbort", 1, 0, 0, 0, 0, 0, 13'h55, 0, 0, 0, 0, 13'd1, 0, 0, 0);

    // Underflow.
    step("unf", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 13'd1, 0, 2, 0);
    step("unfSticky", 1, 0, 0, 1, 13'h40, 0, 0, 0, 0, 0, 0, 13'd1, 0, 2, 0);
    doReset("resetUnf");

    // Fill the stack, then overflow.
    for (int i = 0; i < 8; i++)
      step($sformatf("fill%0d", i), 1, 0, 0, 1, 13'(16'h40 * (i + 1)), 0, 0, 0,
           1, 0, (i == 0) ? 13'd1 : 13'(16'h40 * i + 1), 13'(16'h40 * (i + 1)), 4'(i + 1), 0, 0);
    step("ovf", 1, 0, 0, 1, 13'h999, 0, 0, 0, 0, 0, 0, 13'h200, 8, 1, 0);
    step("ovfBr", 1, 1, 13'h10, 0, 0, 0, 0, 0, 0, 0, 0, 13'h200, 8, 1, 0);
    step("ovfRet", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 13'h200, 8, 1, 0);
    doReset("resetOvf");

    // Stack-reported error outranks a call.
    step("stkErr", 1, 0, 0, 1, 13'h123, 0, 0, 1, 0, 0, 0, 13'd0, 0, 3, 0);
    step("stkSticky", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13'd0, 0, 3, 0);
    doReset("resetStk");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_flow_controller.md
# pc_flow_controller

Sequencer for the instruction-fetch PC and the 8-entry return-address stack. Each cycle it selects the next PC: sequential, branch, call, or return. It drives the stack's push/pop strobes and tracks stack depth so that overflow and underflow never reach the stack. The block sits in IF between the control unit (UC), which raises branch/call/return requests, and the stack, which holds return addresses.

## Interface
- PC_W, 13, PC and stack data width
- DEPTH, 8, stack capacity in entries
- RESET_PC, 0, PC value after reset

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  advance enable; 0 = pipeline stall
- branch  in  1  taken-branch request
- branch_target  in  PC_W  branch destination
- call  in  1  call request
- call_target  in  PC_W  call destination
- ret  in  1  return request
- stack_pop_data  in  PC_W  stack output, valid the cycle after a pop
- stack_overflow  in  1  stack's own error flag
- pc  out  PC_W  current fetch PC (registered)
- stack_push  out  1  write strobe to stack (combinational)
- stack_pop  out  1  read strobe to stack (combinational)
- stack_push_data  out  PC_W  return address = pc+1
- busy  out  1  return in flight; UC requests ignored
- fault  out  2  00 none, 01 overflow, 10 underflow, 11 stack-reported error
- depth  out  4  live entries, 0..DEPTH

## Operation
- FSM states: RUN, RET_WAIT, FAULT.
- RUN with en=1 uses priority ret > call > branch > sequential. Only the winning request acts.
  - ret, depth>0: stack_pop=1, depth-1, go to RET_WAIT, pc holds.
  - ret, depth=0: no pop, fault=10, go to FAULT.
  - call, depth<DEPTH: stack_push=1 with stack_push_data=pc+1, depth+1, pc<=call_target.
  - call, depth=DEPTH: no push, fault=01, go to FAULT.
  - branch: pc<=branch_target.
  - none: pc<=pc+1.
- RUN with en=0: pc, depth, and state hold; no strobes; requests are dropped.
- RET_WAIT: pc<=stack_pop_data, then RUN. This completes regardless of en. busy=1, no strobes.
- FAULT: sticky until reset. pc and depth frozen, strobes 0, busy=0.
- stack_overflow=1 sampled in RUN or RET_WAIT: go to FAULT with fault=11. This takes precedence over all requests.
- Arithmetic: pc+1 is modulo 2^PC_W, so 8191+1 = 0. depth never leaves 0..DEPTH.

## Timing
- Reset (async assert, sync-safe release): pc=RESET_PC, depth=0, state=RUN, fault=00, busy=0, strobes=0.
- Reset asserted mid-RET_WAIT aborts the return. No pop is completed after release.
- Call, branch, and sequential each take 1 cycle: request in cycle T, new pc visible in T+1.
- Return takes 2 cycles: pop in T, RET_WAIT in T+1, return address on pc in T+2.
- Strobes are combinational from state/inputs. They assert at most one cycle per request and never both together.
- Fault output is registered; it updates in the cycle after the offending request.

## Structure
- Shared package musa_if_pkg holds:
  - PC_W and DEPTH constants.
  - FSM state encoding: RUN=2'd0, RET_WAIT=2'd1, FAULT=2'd2.
  - Fault codes: FLT_NONE, FLT_OVF, FLT_UNF, FLT_STK.
- One sub-module, pc_depth_counter: saturating up/down counter 0..DEPTH with full/empty flags. The controller's push/pop legality checks use these flags.

## Test plan
- Reset then 4 cycles en=1 with no requests → pc 0,1,2,3,4; no strobes.
- At pc=10: call to 0x100, then ret at pc=0x100.
  - Call cycle: push with data 11; pc=0x100 next cycle.
  - Ret: pop, one busy cycle, then pc=11; depth back to 0.
- 8 nested calls then a 9th → 8 pushes, depth=8; 9th gives no push, fault=01, pc frozen; only reset clears it.
- ret at depth=0 → no pop, fault=10.
- Same-cycle ret+call+branch at depth=1 → only pop occurs. Same-cycle call+branch → push, pc=call_target.
- Stall and wrap:
  - en=0 for 3 cycles → pc holds, requests dropped.
  - pc=8191, call → push_data=0.
  - Reset asserted during RET_WAIT → pc=RESET_PC, depth=0.
